minmax_tracker: RTL and testbench



---
 rtl/minmax_pkg.sv | 24 ++
 rtl/cmp8.sv | 28 ++
 rtl/minmax_tracker.sv | 168 ++++++++++++++++
 tb/tb_minmax_tracker.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/minmax_pkg.sv
// -----------------------------------------------------------------------------
// minmax_pkg
//   Shared types and constants for the frame min/max tracker.
//   - minmax_state_t : frame sequencer states (IDLE, RUN, DONE)
//   - cmp_res_t      : three-way magnitude result produced by cmp8
//   - MINMAX_FRAME_LEN_DEF : default number of samples per frame
// -----------------------------------------------------------------------------
package minmax_pkg;

    localparam int MINMAX_FRAME_LEN_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } minmax_state_t;

    typedef enum logic [1:0] {
        LESS    = 2'd0,
        EQUAL   = 2'd1,
        GREATER = 2'd2
    } cmp_res_t;

endpackage : minmax_pkg

// File: rtl/cmp8.sv
// -----------------------------------------------------------------------------
// cmp8
//   Unsigned 8-bit magnitude comparator. Reports how a_i relates to b_i.
//   Ports:
//     a_i   in  8  : left operand
//     b_i   in  8  : right operand
//     res_o out 2  : LESS (a<b), EQUAL (a==b), GREATER (a>b)
// -----------------------------------------------------------------------------
module cmp8
    import minmax_pkg::*;
(
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output cmp_res_t   res_o
);

    // NOTE: every path through an always_comb block must assign the output;
    // assigning a default first guarantees no latch is inferred.
    always_comb begin
        res_o = EQUAL;
        if (a_i > b_i) begin
            res_o = GREATER;
        end else if (a_i < b_i) begin
            res_o = LESS;
        end
    end

endmodule : cmp8

// File: rtl/minmax_tracker.sv
// -----------------------------------------------------------------------------
// minmax_tracker
//   Frame-based running minimum/maximum tracker. A frame starts on `start`
//   (IDLE only), accepts FRAME_LEN samples through a valid/ready handshake
//   and then presents one result record through a valid/ready output.
//   Result registers keep the last frame's values until the first sample of
//   the next frame is accepted.
//
//   Build option: define MINMAX_ABORT_EN to add the `abort` input, which
//   drops an in-progress frame (RUN only) without emitting a record.
//
//   Ports:
//     clk, rst_n         : clock, asynchronous active-low reset
//     start              : begin a frame (honoured in IDLE only)
//     in_valid/in_ready  : sample handshake (in_ready high only in RUN)
//     in_data            : unsigned 8-bit sample
//     out_valid/out_ready: result handshake (out_valid high only in DONE)
//     out_max, out_min   : frame extremes
//     out_max_idx/min_idx: 0-based frame position of each extreme
//     busy               : high in RUN and DONE
//     abort              : (MINMAX_ABORT_EN only) drop the current frame
// -----------------------------------------------------------------------------
module minmax_tracker
    import minmax_pkg::*;
#(
    parameter int FRAME_LEN = MINMAX_FRAME_LEN_DEF,
    parameter int IDX_W     = $clog2(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_max,
    output logic [7:0]       out_min,
    output logic [IDX_W-1:0] out_max_idx,
    output logic [IDX_W-1:0] out_min_idx,
    output logic             busy
`ifdef MINMAX_ABORT_EN
    ,
    input  logic             abort
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    minmax_state_t    state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [7:0]       max_q, max_d;
    logic [7:0]       min_q, min_d;
    logic [IDX_W-1:0] max_idx_q, max_idx_d;
    logic [IDX_W-1:0] min_idx_q, min_idx_d;

    cmp_res_t max_cmp;
    cmp_res_t min_cmp;
    logic     abort_w;
    logic     accept;

`ifdef MINMAX_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // Sample against the running max / min of the current frame.
    cmp8 u_cmp_max (
        .a_i   (in_data),
        .b_i   (max_q),
        .res_o (max_cmp)
    );

    cmp8 u_cmp_min (
        .a_i   (in_data),
        .b_i   (min_q),
        .res_o (min_cmp)
    );

    // Handshake and status outputs are pure state decodes, so no input
    // reaches an output combinationally.
    assign in_ready  = (state_q == RUN);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        max_d     = max_q;
        min_d     = min_q;
        max_idx_d = max_idx_q;
        min_idx_d = min_idx_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end

            RUN: begin
                // Abort takes priority over a coincident accept, including
                // the final sample: nothing is updated and DONE is skipped.
                if (abort_w) begin
                    state_d = IDLE;
                end else if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == '0) begin
                        max_d     = in_data;
                        min_d     = in_data;
                        max_idx_d = '0;
                        min_idx_d = '0;
                    end else begin
                        // Strict comparisons keep the earliest index on ties.
                        if (max_cmp == GREATER) begin
                            max_d     = in_data;
                            max_idx_d = cnt_q;
                        end
                        if (min_cmp == LESS) begin
                            min_d     = in_data;
                            min_idx_d = cnt_q;
                        end
                    end
                    if (cnt_q == LAST_IDX) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            max_q     <= '0;
            min_q     <= '0;
            max_idx_q <= '0;
            min_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            max_q     <= max_d;
            min_q     <= min_d;
            max_idx_q <= max_idx_d;
            min_idx_q <= min_idx_d;
        end
    end

    assign out_max     = max_q;
    assign out_min     = min_q;
    assign out_max_idx = max_idx_q;
    assign out_min_idx = min_idx_q;

endmodule : minmax_tracker

// File: tb/tb_minmax_tracker.sv
// -----------------------------------------------------------------------------
// tb_minmax_tracker
//   Self-checking bench for minmax_tracker with FRAME_LEN=4. Frame results
//   are compared with a reference model that takes the max/min over the
//   stored frame and then searches for the first position holding it.
//   Exercises the abort input when MINMAX_ABORT_EN is defined.
// -----------------------------------------------------------------------------
module tb_minmax_tracker;

    localparam int FL = 4;
    localparam int IW = $clog2(FL);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_data = 8'h00;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [7:0]    out_max;
    logic [7:0]    out_min;
    logic [IW-1:0] out_max_idx;
    logic [IW-1:0] out_min_idx;
    logic          busy;
`ifdef MINMAX_ABORT_EN
    logic          abort = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] frm [FL];

    minmax_tracker #(.FRAME_LEN(FL)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_max     (out_max),
        .out_min     (out_min),
        .out_max_idx (out_max_idx),
        .out_min_idx (out_min_idx),
        .busy        (busy)
`ifdef MINMAX_ABORT_EN
        ,
        .abort       (abort)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: extreme values first, then the earliest position holding them.
    task automatic ref_model(output logic [7:0] mx, output logic [7:0] mn,
                             output int mxi, output int mni);
        mx = 8'h00;
        mn = 8'hFF;
        foreach (frm[i]) begin
            if (frm[i] > mx) mx = frm[i];
            if (frm[i] < mn) mn = frm[i];
        end
        mxi = -1;
        mni = -1;
        for (int i = FL - 1; i >= 0; i--) begin
            if (frm[i] == mx) mxi = i;
            if (frm[i] == mn) mni = i;
        end
    endtask

    task automatic check_result(input string tag);
        logic [7:0] mx, mn;
        int         mxi, mni;
        ref_model(mx, mn, mxi, mni);
        check({tag, "_max"},     32'(out_max),     32'(mx));
        check({tag, "_min"},     32'(out_min),     32'(mn));
        check({tag, "_max_idx"}, 32'(out_max_idx), 32'(mxi));
        check({tag, "_min_idx"}, 32'(out_min_idx), 32'(mni));
    endtask

    task automatic start_frame(input string tag);
        start = 1'b1;
        step();
        start = 1'b0;
        check({tag, "_start_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_start_busy"},     32'(busy),     32'd1);
    endtask

    // Present frm[0..n-1]; with gaps, in_valid is dropped at random and the
    // data bus carries garbage while invalid.
    task automatic feed(input string tag, input int n, input bit gaps);
        int  i = 0;
        int  budget = 0;
        bit  acc;
        while (i < n) begin
            if (budget > 200) begin
                check({tag, "_feed_timeout"}, 32'd0, 32'd1);
                break;
            end
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = in_valid ? frm[i] : 8'($urandom);
            acc      = in_valid && in_ready;
            step();
            budget++;
            if (acc) i++;
        end
        in_valid = 1'b0;
    endtask

    // Called right after the last accept. Holds out_ready low for `hold`
    // cycles (with a stray start), then completes the handshake.
    task automatic finish_frame(input string tag, input int hold);
        logic [7:0]    mx, mn;
        logic [IW-1:0] mxi, mni;
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_in_ready0"}, 32'(in_ready),  32'd0);
        check_result(tag);
        mx  = out_max;
        mn  = out_min;
        mxi = out_max_idx;
        mni = out_min_idx;
        for (int k = 0; k < hold; k++) begin
            start = (k == 1);
            step();
            start = 1'b0;
            check({tag, "_bp_valid"},    32'(out_valid),   32'd1);
            check({tag, "_bp_in_ready"}, 32'(in_ready),    32'd0);
            check({tag, "_bp_max"},      32'(out_max),     32'(mx));
            check({tag, "_bp_min"},      32'(out_min),     32'(mn));
            check({tag, "_bp_max_idx"},  32'(out_max_idx), 32'(mxi));
            check({tag, "_bp_min_idx"},  32'(out_min_idx), 32'(mni));
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_idle_busy"},  32'(busy),      32'd0);
        check({tag, "_keep_max"},   32'(out_max),   32'(mx));
        check({tag, "_keep_min"},   32'(out_min),   32'(mn));
        step();
        check({tag, "_no_queued_start"}, 32'(busy), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),    32'd0);
        check({tag, "_out_valid"}, 32'(out_valid),   32'd0);
        check({tag, "_busy"},      32'(busy),        32'd0);
        check({tag, "_max"},       32'(out_max),     32'd0);
        check({tag, "_min"},       32'(out_min),     32'd0);
        check({tag, "_max_idx"},   32'(out_max_idx), 32'd0);
        check({tag, "_min_idx"},   32'(out_min_idx), 32'd0);
    endtask

    initial begin
        // Reset state.
        #12;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("idle_after_reset_busy", 32'(busy), 32'd0);

        // Basic frame with explicit expectations.
        frm = '{8'h10, 8'h80, 8'h05, 8'h80};
        start_frame("basic");
        feed("basic", FL, 1'b0);
        check("basic_max_const",     32'(out_max),     32'h80);
        check("basic_max_idx_const", 32'(out_max_idx), 32'd1);
        check("basic_min_const",     32'(out_min),     32'h05);
        check("basic_min_idx_const", 32'(out_min_idx), 32'd2);
        finish_frame("basic", 0);

        // Boundary values and ties.
        frm = '{8'hFF, 8'h00, 8'hFF, 8'h00};
        start_frame("bound");
        feed("bound", FL, 1'b0);
        check("bound_max_const",     32'(out_max),     32'hFF);
        check("bound_max_idx_const", 32'(out_max_idx), 32'd0);
        check("bound_min_const",     32'(out_min),     32'h00);
        check("bound_min_idx_const", 32'(out_min_idx), 32'd1);
        finish_frame("bound", 0);

        // Backpressure on a random frame.
        foreach (frm[i]) frm[i] = 8'($urandom);
        start_frame("bp");
        feed("bp", FL, 1'b0);
        finish_frame("bp", 5);

        // Input gaps on the basic frame.
        frm = '{8'h10, 8'h80, 8'h05, 8'h80};
        start_frame("gaps");
        feed("gaps", FL, 1'b1);
        check("gaps_max_idx_const", 32'(out_max_idx), 32'd1);
        check("gaps_min_idx_const", 32'(out_min_idx), 32'd2);
        finish_frame("gaps", 0);

        // Random frames; narrow value ranges on odd frames force ties.
        for (int f = 0; f < 8; f++) begin
            foreach (frm[i]) frm[i] = (f % 2) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            start_frame("rand");
            feed("rand", FL, f[1]);
            finish_frame("rand", f % 3);
        end

        // Reset mid-frame.
        frm = '{8'h33, 8'h99, 8'h11, 8'h77};
        start_frame("midrst");
        feed("midrst", 2, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("midrst_no_record", 32'(out_valid), 32'd0);
        start_frame("postrst");
        feed("postrst", FL, 1'b0);
        finish_frame("postrst", 0);

`ifdef MINMAX_ABORT_EN
        // Abort on the final sample: no record, earlier results retained.
        frm = '{8'h10, 8'h80, 8'h05, 8'h80};
        start_frame("abort_ref");
        feed("abort_ref", FL, 1'b0);
        finish_frame("abort_ref", 0);
        start_frame("abort");
        feed("abort", FL - 1, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        abort    = 1'b1;
        step();
        abort    = 1'b0;
        in_valid = 1'b0;
        check("abort_out_valid", 32'(out_valid),   32'd0);
        check("abort_busy",      32'(busy),        32'd0);
        check("abort_in_ready",  32'(in_ready),    32'd0);
        check("abort_max",       32'(out_max),     32'h80);
        check("abort_min",       32'(out_min),     32'h05);
        check("abort_max_idx",   32'(out_max_idx), 32'd1);
        check("abort_min_idx",   32'(out_min_idx), 32'd2);
        step();
        check("abort_still_no_record", 32'(out_valid), 32'd0);

        // Abort in IDLE is ignored: start still begins a frame.
        abort = 1'b1;
        start_frame("abort_idle");
        abort = 1'b0;
        frm = '{8'h44, 8'h22, 8'h66, 8'h22};
        feed("abort_idle", FL, 1'b0);
        finish_frame("abort_idle", 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_minmax_tracker
